// File: rtl/ppf_pkg.sv
// Shared PPF chain definitions: phase count, phase index width, strobe classes
// and the lane slice helper used by the commutator, collector and filter bank.
package ppf_pkg;
    localparam int PPF_NUM_PHASES = 8;
    localparam int PPF_PHASE_W    = 3;
    localparam int PPF_LANE_W     = 32;

    typedef enum logic [2:0] {
        UPD_IDLE,
        UPD_ACCEPT,
        UPD_COMPLETE,
        UPD_RESYNC,
        UPD_ERROR
    } ppf_upd_e;

    function automatic logic [PPF_LANE_W-1:0] lane(
        input logic [PPF_NUM_PHASES*PPF_LANE_W-1:0] bus,
        input logic [PPF_PHASE_W-1:0]               k
    );
        return bus[int'(k)*PPF_LANE_W +: PPF_LANE_W];
    endfunction
endpackage

// File: rtl/ppf_frame_fifo.sv
// Frame FIFO: synchronous, first-word fall-through, with a registered read port
// so the storage array maps onto block RAM.
module ppf_frame_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    count_reg, count_next;
    logic             wr_en, rd_en, bypass;

    assign full  = (count_reg == LW'(DEPTH));
    assign empty = (count_reg == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || rd_en);
    assign rd_ptr_next = rd_ptr_reg + AW'(rd_en);
    // The incoming word is the next head only when it will be the sole occupant.
    assign bypass = wr_en && (wr_ptr_reg == rd_ptr_next);

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en)
            count_next = count_reg + 1'b1;
        else if (!wr_en && rd_en)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (wr_en)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(wr_en);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            dout_reg   <= bypass ? din : mem[rd_ptr_next];
        end
    end

    assign dout  = dout_reg;
    assign level = count_reg;
endmodule

// File: rtl/ppf_frame_collector.sv
// PPF frame collector: assembles in-order phase strobes into aligned 8-lane frames
// and streams them from a small frame FIFO as an AXI-stream master.
module ppf_frame_collector
    import ppf_pkg::*;
#(
    parameter int TDATA_WIDTH    = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int FRAMES_PER_PKT = 16
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETn,
    input  logic [PPF_NUM_PHASES*TDATA_WIDTH-1:0] ch_data_i,
    input  logic [PPF_NUM_PHASES-1:0]             ch_upd_i,
    input  logic                                  clr_i,
    output logic [PPF_NUM_PHASES*TDATA_WIDTH-1:0] M_TDATA,
    output logic                                  M_TVALID,
    output logic                                  M_TLAST,
    input  logic                                  M_TREADY,
    output logic                                  phase_err_o,
    output logic                                  ovf_o,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level_o
);
    localparam int FW  = PPF_NUM_PHASES * TDATA_WIDTH;
    localparam int PCW = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
    localparam logic [PPF_PHASE_W-1:0]    LAST_PH  = PPF_PHASE_W'(PPF_NUM_PHASES - 1);
    localparam logic [PPF_NUM_PHASES-1:0] PH0_MASK = 1;
    localparam logic [PCW-1:0]            LAST_CNT = PCW'(FRAMES_PER_PKT - 1);

    logic [PPF_PHASE_W-1:0]    exp_ph_reg, exp_ph_next;
    logic [PPF_NUM_PHASES-1:0] exp_mask;
    ppf_upd_e                  upd_cls;
    logic [FW-1:0]             frame;
    logic                      phase_err_reg, ovf_reg, ovf_next;
    logic [PCW-1:0]            pkt_cnt_reg;
    logic                      push, pop, overflow, fifo_full, fifo_empty;

    assign exp_mask = PH0_MASK << exp_ph_reg;

    always_comb begin
        upd_cls     = UPD_IDLE;
        exp_ph_next = exp_ph_reg;
        if (ch_upd_i == '0) begin
            upd_cls = UPD_IDLE;
        end else if (ch_upd_i == exp_mask) begin
            upd_cls     = (exp_ph_reg == LAST_PH) ? UPD_COMPLETE : UPD_ACCEPT;
            exp_ph_next = exp_ph_reg + 1'b1;
        end else if (ch_upd_i == PH0_MASK) begin
            // A stray phase-0 strobe starts a fresh frame instead of being thrown away.
            upd_cls     = UPD_RESYNC;
            exp_ph_next = PPF_PHASE_W'(1);
        end else begin
            upd_cls     = UPD_ERROR;
            exp_ph_next = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PPF_NUM_PHASES - 1; gi++) begin : g_lane
            logic [TDATA_WIDTH-1:0] shadow_reg;
            logic                   latch_en;

            assign latch_en = (upd_cls == UPD_ACCEPT && exp_ph_reg == PPF_PHASE_W'(gi))
                           || (gi == 0 && upd_cls == UPD_RESYNC);

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn)
                    shadow_reg <= '0;
                else if (latch_en)
                    shadow_reg <= ch_data_i[gi*TDATA_WIDTH +: TDATA_WIDTH];
            end

            assign frame[gi*TDATA_WIDTH +: TDATA_WIDTH] = shadow_reg;
        end
    endgenerate

    // The last phase goes straight from the input into the frame, saving a cycle.
    assign frame[(PPF_NUM_PHASES-1)*TDATA_WIDTH +: TDATA_WIDTH] =
        ch_data_i[(PPF_NUM_PHASES-1)*TDATA_WIDTH +: TDATA_WIDTH];

    assign push     = (upd_cls == UPD_COMPLETE);
    assign pop      = !fifo_empty && M_TREADY;
    assign overflow = push && fifo_full && !pop;

    ppf_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (push),
        .din     (frame),
        .pop     (pop),
        .dout    (M_TDATA),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    always_comb begin
        ovf_next = ovf_reg;
        if (clr_i)
            ovf_next = 1'b0;
        if (overflow)
            ovf_next = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            exp_ph_reg    <= '0;
            phase_err_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            pkt_cnt_reg   <= '0;
        end else begin
            exp_ph_reg    <= exp_ph_next;
            phase_err_reg <= (upd_cls == UPD_ERROR) || (upd_cls == UPD_RESYNC);
            ovf_reg       <= ovf_next;
            if (pop)
                pkt_cnt_reg <= (pkt_cnt_reg == LAST_CNT) ? '0 : pkt_cnt_reg + 1'b1;
        end
    end

    assign M_TVALID    = !fifo_empty;
    assign M_TLAST     = !fifo_empty && (pkt_cnt_reg == LAST_CNT);
    assign phase_err_o = phase_err_reg;
    assign ovf_o       = ovf_reg;
endmodule

// File: tb/tb_ppf_frame_collector.sv
// Bench for ppf_frame_collector: strobe table plus hand-written overflow, backpressure,
// full-boundary and reset sequences, with a queue scoreboard on the AXI output.
module tb_ppf_frame_collector;
    import ppf_pkg::*;

    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [255:0] ch_data_i;
    logic [7:0]   ch_upd_i;
    logic         clr_i;
    logic [255:0] M_TDATA;
    logic         M_TVALID, M_TLAST, M_TREADY;
    logic         phase_err_o, ovf_o;
    logic [2:0]   fifo_level_o;

    ppf_frame_collector #(
        .TDATA_WIDTH    (32),
        .FIFO_DEPTH     (4),
        .FRAMES_PER_PKT (16)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .ch_data_i    (ch_data_i),
        .ch_upd_i     (ch_upd_i),
        .clr_i        (clr_i),
        .M_TDATA      (M_TDATA),
        .M_TVALID     (M_TVALID),
        .M_TLAST      (M_TLAST),
        .M_TREADY     (M_TREADY),
        .phase_err_o  (phase_err_o),
        .ovf_o        (ovf_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0] upd;
        logic [7:0] gen;
        logic       err;
        logic       push;
    } vec_t;

    vec_t         tbl[$];
    logic [255:0] sb[$];
    int           total = 0;
    int           bad = 0;
    int           hs_cnt = 0;
    int           last_cnt = 0;
    int           cyc = 0;
    bit           rand_ready_en = 0;
    bit           stall_pending = 0;
    logic [255:0] stall_data;
    logic         stall_last;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_frame(input logic [7:0] gen);
        logic [255:0] f;
        for (int k = 0; k < 8; k++)
            f[k*32 +: 32] = {gen, 8'(k), 16'h1000 | 16'(k)};
        return f;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic strobe(input int k, input logic [255:0] data);
        ch_upd_i  = 8'(1 << k);
        ch_data_i = data;
        tick();
        ch_upd_i = '0;
    endtask

    task automatic send_frame(input logic [7:0] gen, input bit accepted);
        for (int k = 0; k < 8; k++) begin
            if (k == 7 && accepted)
                sb.push_back(mk_frame(gen));
            strobe(k, mk_frame(gen));
            chk("perr_in_order", phase_err_o, 1'b0);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || M_TVALID) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, (sb.size() == 0 && !M_TVALID), 1'b1);
    endtask

    task automatic do_reset(input string name);
        ARESETn = 1'b0;
        sb.delete();
        hs_cnt = 0;
        #1;
        chk({name, "_rst_tvalid"}, M_TVALID, 1'b0);
        chk({name, "_rst_tlast"}, M_TLAST, 1'b0);
        chk({name, "_rst_tdata"}, M_TDATA, '0);
        chk({name, "_rst_perr"}, phase_err_o, 1'b0);
        chk({name, "_rst_ovf"}, ovf_o, 1'b0);
        chk({name, "_rst_level"}, fifo_level_o, 3'd0);
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic add(input logic [7:0] upd, input logic [7:0] gen, input logic err, input logic push);
        vec_t v;
        v.upd = upd; v.gen = gen; v.err = err; v.push = push;
        tbl.push_back(v);
    endtask

    // Output monitor: handshakes pop the scoreboard; stalls must hold TDATA/TLAST.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            stall_pending = 0;
        end else begin
            if (stall_pending) begin
                chk("stall_tvalid", M_TVALID, 1'b1);
                chk("stall_tdata", M_TDATA, stall_data);
                chk("stall_tlast", M_TLAST, stall_last);
            end
            stall_pending = M_TVALID && !M_TREADY;
            stall_data    = M_TDATA;
            stall_last    = M_TLAST;
            if (M_TVALID && M_TREADY) begin
                $display("frame %0d data=%h last=%0b", hs_cnt, M_TDATA, M_TLAST);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame_unexpected: got=%h expected=none", M_TDATA);
                end else begin
                    chk("frame_data", M_TDATA, sb.pop_front());
                end
                chk("frame_tlast", M_TLAST, (hs_cnt % 16) == 15);
                if (M_TLAST) last_cnt++;
                hs_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        cyc++;
        if (rand_ready_en)
            M_TREADY = ((cyc % 4) == 0) || ($urandom_range(0, 1) == 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b0; ch_data_i = '0; ch_upd_i = '0; clr_i = 1'b0; M_TREADY = 1'b1;

        // Phase-order table: 0,1,2,5 error, resync on a stray phase 0, multi-bit, gaps.
        add(8'h01, 8'h21, 0, 0); add(8'h02, 8'h21, 0, 0); add(8'h04, 8'h21, 0, 0);
        add(8'h20, 8'h21, 1, 0); add(8'h00, 8'h21, 0, 0);
        for (int k = 0; k < 8; k++) add(8'(1 << k), 8'h22, 0, k == 7);
        add(8'h01, 8'h23, 0, 0); add(8'h02, 8'h23, 0, 0); add(8'h01, 8'h24, 1, 0);
        for (int k = 1; k < 8; k++) add(8'(1 << k), 8'h24, 0, k == 7);
        add(8'h03, 8'h25, 1, 0); add(8'h80, 8'h25, 1, 0); add(8'h00, 8'h25, 0, 0);
        add(8'h01, 8'h26, 0, 0); add(8'h00, 8'h26, 0, 0); add(8'h02, 8'h26, 0, 0);
        add(8'h04, 8'h26, 0, 0); add(8'h00, 8'h26, 0, 0); add(8'h08, 8'h26, 0, 0);
        add(8'h10, 8'h26, 0, 0); add(8'h20, 8'h26, 0, 0); add(8'h40, 8'h26, 0, 0);
        add(8'h80, 8'h26, 0, 1); add(8'h80, 8'h27, 1, 0); add(8'h00, 8'h27, 0, 0);

        repeat (3) tick();
        chk("rst_tvalid", M_TVALID, 1'b0);
        chk("rst_tlast", M_TLAST, 1'b0);
        chk("rst_perr", phase_err_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_level", fifo_level_o, 3'd0);
        chk("rst_tdata", M_TDATA, '0);
        ARESETn = 1'b1;
        tick();

        // Test 1: ordered frame, lane k = 32'h000k_100k, visible one cycle after phase 7.
        send_frame(8'h00, 1);
        chk("t1_tvalid", M_TVALID, 1'b1);
        chk("t1_level", fifo_level_o, 3'd1);
        for (int k = 0; k < 8; k++)
            chk("t1_lane", lane(M_TDATA, 3'(k)), {16'(k), 16'h1000 | 16'(k)});
        wait_drain(10, "t1");

        // Test 2: table-driven phase sequences.
        foreach (tbl[i]) begin
            ch_upd_i  = tbl[i].upd;
            ch_data_i = mk_frame(tbl[i].gen);
            if (tbl[i].push)
                sb.push_back(mk_frame(tbl[i].gen));
            tick();
            ch_upd_i = '0;
            $display("row %0d upd=%02h gen=%02h perr=%0b", i, tbl[i].upd, tbl[i].gen, phase_err_o);
            chk("tbl_perr", phase_err_o, tbl[i].err);
        end
        wait_drain(10, "t2");

        // Test 3: overflow with clr_i coinciding, then sticky until an isolated clear.
        M_TREADY = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(8'h31 + 8'(f), 1);
        chk("t3_level_full", fifo_level_o, 3'd4);
        chk("t3_ovf_pre", ovf_o, 1'b0);
        for (int k = 0; k < 7; k++) strobe(k, mk_frame(8'h35));
        ch_upd_i = 8'h80; clr_i = 1'b1;
        tick();
        ch_upd_i = '0; clr_i = 1'b0;
        chk("t3_ovf_set", ovf_o, 1'b1);
        chk("t3_level_sat", fifo_level_o, 3'd4);
        tick();
        chk("t3_ovf_sticky", ovf_o, 1'b1);
        M_TREADY = 1'b1;
        wait_drain(20, "t3");
        chk("t3_ovf_held", ovf_o, 1'b1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("t3_ovf_clr", ovf_o, 1'b0);

        // Test 5: push and pop together while full.
        M_TREADY = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(8'h50 + 8'(f), 1);
        chk("t5_level_full", fifo_level_o, 3'd4);
        for (int k = 0; k < 7; k++) strobe(k, mk_frame(8'h54));
        sb.push_back(mk_frame(8'h54));
        ch_upd_i = 8'h80; M_TREADY = 1'b1;
        tick();
        ch_upd_i = '0; M_TREADY = 1'b0;
        chk("t5_ovf", ovf_o, 1'b0);
        chk("t5_level", fifo_level_o, 3'd4);
        M_TREADY = 1'b1;
        wait_drain(20, "t5");

        // Test 4: random backpressure over 40 frames, packet counter from reset.
        do_reset("t4");
        last_cnt = 0;
        rand_ready_en = 1;
        for (int f = 0; f < 40; f++) send_frame(8'h80 + 8'(f), 1);
        wait_drain(100, "t4");
        rand_ready_en = 0;
        M_TREADY = 1'b1;
        chk("t4_frames", hs_cnt, 40);
        chk("t4_tlast_count", last_cnt, 2);
        chk("t4_ovf", ovf_o, 1'b0);

        // Test 6: reset in the middle of a frame with a full FIFO and overflow set.
        M_TREADY = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(8'h70 + 8'(f), f < 4);
        chk("t6_ovf_pre", ovf_o, 1'b1);
        for (int k = 0; k < 5; k++) strobe(k, mk_frame(8'h61));
        do_reset("t6");
        M_TREADY = 1'b1;
        send_frame(8'h62, 1);
        chk("t6_tvalid", M_TVALID, 1'b1);
        wait_drain(10, "t6");

        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
